// File: rtl/quad2_gate_ic_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : quad2_gate_ic_emulator_pkg
// Brief   : Gate-code encoding shared with the checker's gate-select mux, and
//           the emulator's operating states.
// Revision: 1.0 - initial release
// ============================================================================
package quad2_gate_ic_emulator_pkg;

    localparam logic [2:0] c_gate_and     = 3'd0;
    localparam logic [2:0] c_gate_or      = 3'd1;
    localparam logic [2:0] c_gate_nand    = 3'd2;
    localparam logic [2:0] c_gate_nor     = 3'd3;
    localparam logic [2:0] c_gate_xor     = 3'd4;
    localparam logic [2:0] c_gate_xnor    = 3'd5;
    localparam logic [2:0] c_gate_invalid = 3'd7;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } emu_state_e;

endpackage : quad2_gate_ic_emulator_pkg
`default_nettype wire

// File: rtl/quad2_gate_ic_emulator_gate_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : gate_delay_line
// Brief   : DEPTH-deep, WIDTH-wide shift register with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
module gate_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [DEPTH*WIDTH-1:0] r_shift;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (rst || i_clr) begin
                r_shift <= '0;
            end else begin
                r_shift <= i_din;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (rst || i_clr) begin
                r_shift <= '0;
            end else begin
                r_shift <= {r_shift[(DEPTH-1)*WIDTH-1:0], i_din};
            end
        end
    end

    assign o_dout = r_shift[DEPTH*WIDTH-1 -: WIDTH];

endmodule : gate_delay_line
`default_nettype wire

// File: rtl/quad2_gate_ic_emulator.sv
`default_nettype none
// ============================================================================
// Module  : quad2_gate_ic_emulator
// Brief   : Quad two-input gate IC model with configurable function, stuck-at
//           fault injection, emulated supply and propagation delay.
// Revision: 1.0 - initial release
// ============================================================================
module quad2_gate_ic_emulator
    import quad2_gate_ic_emulator_pkg::*;
#(
    parameter int PROP_DELAY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A1,
    input  logic             A2,
    input  logic             A3,
    input  logic             A4,
    input  logic             B1,
    input  logic             B2,
    input  logic             B3,
    input  logic             B4,
    output logic             op1,
    output logic             op2,
    output logic             op3,
    output logic             op4,
    input  logic             powered,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_gate,
    input  logic [3:0]       cfg_fault_mask,
    input  logic [3:0]       cfg_fault_val,
    output logic             busy,
    output logic [CNT_W-1:0] toggle_count
);

    localparam int                  c_flush_w    = (PROP_DELAY > 1) ? $clog2(PROP_DELAY) : 1;
    localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(PROP_DELAY - 1);

    function automatic logic gate_eval(input logic [2:0] code, input logic a, input logic b);
        case (code)
            c_gate_and:  return a & b;
            c_gate_or:   return a | b;
            c_gate_nand: return ~(a & b);
            c_gate_nor:  return ~(a | b);
            c_gate_xor:  return a ^ b;
            c_gate_xnor: return ~(a ^ b);
            default:     return 1'b0;
        endcase
    endfunction

    // Input vector layout: {B4..B1, A4..A1}
    logic [7:0]           r_in;
    logic [7:0]           r_in_prev;
    logic [CNT_W-1:0]     r_toggle;
    logic [2:0]           r_cfg_gate;
    logic [3:0]           r_cfg_mask;
    logic [3:0]           r_cfg_val;
    emu_state_e           r_state;
    emu_state_e           w_state_next;
    logic [c_flush_w-1:0] r_flush_cnt;
    logic [c_flush_w-1:0] w_flush_cnt_next;
    logic                 w_cfg_xfer;
    logic                 w_line_clr;
    logic [3:0]           w_gate;
    logic [3:0]           w_delayed;
    logic [3:0]           w_faulted;
    logic                 w_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in      <= '0;
            r_in_prev <= '0;
            r_toggle  <= '0;
        end else begin
            r_in      <= {B4, B3, B2, B1, A4, A3, A2, A1};
            r_in_prev <= r_in;
            if ((r_in != r_in_prev) && (r_toggle != {CNT_W{1'b1}})) begin
                r_toggle <= r_toggle + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_gate
        assign w_gate[i] = gate_eval(r_cfg_gate, r_in[i], r_in[i+4]);
    end

    gate_delay_line #(
        .DEPTH (PROP_DELAY),
        .WIDTH (4)
    ) u_delay_line (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_line_clr),
        .i_din  (w_gate),
        .o_dout (w_delayed)
    );

    // Losing power wins over any pending configuration transfer.
    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_cfg_xfer       = 1'b0;
        w_line_clr       = 1'b0;
        if (!powered) begin
            w_state_next     = ST_OFF;
            w_flush_cnt_next = '0;
            w_line_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = '0;
                    w_line_clr       = 1'b1;
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == c_flush_last) begin
                        w_state_next     = ST_RUN;
                        w_flush_cnt_next = '0;
                    end else begin
                        w_flush_cnt_next = r_flush_cnt + c_flush_w'(1);
                    end
                end
                ST_RUN: begin
                    if (cfg_valid) begin
                        w_cfg_xfer       = 1'b1;
                        w_line_clr       = 1'b1;
                        w_state_next     = ST_FLUSH;
                        w_flush_cnt_next = '0;
                    end
                end
                default: begin
                    w_state_next     = ST_OFF;
                    w_flush_cnt_next = '0;
                    w_line_clr       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= powered ? ST_FLUSH : ST_OFF;
            r_flush_cnt <= '0;
            r_cfg_gate  <= c_gate_and;
            r_cfg_mask  <= '0;
            r_cfg_val   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            if (w_cfg_xfer) begin
                r_cfg_gate <= cfg_gate;
                r_cfg_mask <= cfg_fault_mask;
                r_cfg_val  <= cfg_fault_val;
            end
        end
    end

    assign w_live    = (r_state == ST_RUN);
    assign w_faulted = (r_cfg_mask & r_cfg_val) | (~r_cfg_mask & w_delayed);

    assign {op4, op3, op2, op1} = w_live ? w_faulted : 4'b0000;
    assign cfg_ready            = w_live;
    assign busy                 = ~w_live;
    assign toggle_count         = r_toggle;

endmodule : quad2_gate_ic_emulator
`default_nettype wire

// File: tb/tb_quad2_gate_ic_emulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_quad2_gate_ic_emulator
// Brief   : Scoreboard bench: cycle-level reference model feeds an expectation
//           queue that a negedge monitor drains against the emulator outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_quad2_gate_ic_emulator;

    localparam int PD = 4;

    typedef struct packed {
        logic [3:0]  ops;
        logic        busy;
        logic        ready;
        int unsigned cnt16;
        int unsigned cnt2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a_pins;
    logic [3:0]  b_pins;
    logic        powered;
    logic        cfg_valid;
    logic [2:0]  cfg_gate;
    logic [3:0]  cfg_fault_mask;
    logic [3:0]  cfg_fault_val;
    logic [3:0]  ops_w;
    logic [3:0]  ops_s;
    logic        ready_w;
    logic        ready_s;
    logic        busy_w;
    logic        busy_s;
    logic [15:0] tc_w;
    logic [1:0]  tc_s;

    always #5 clk = ~clk;

    quad2_gate_ic_emulator #(.PROP_DELAY(PD), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .A1(a_pins[0]), .A2(a_pins[1]), .A3(a_pins[2]), .A4(a_pins[3]),
        .B1(b_pins[0]), .B2(b_pins[1]), .B3(b_pins[2]), .B4(b_pins[3]),
        .op1(ops_w[0]), .op2(ops_w[1]), .op3(ops_w[2]), .op4(ops_w[3]),
        .powered(powered), .cfg_valid(cfg_valid), .cfg_ready(ready_w),
        .cfg_gate(cfg_gate), .cfg_fault_mask(cfg_fault_mask), .cfg_fault_val(cfg_fault_val),
        .busy(busy_w), .toggle_count(tc_w)
    );

    quad2_gate_ic_emulator #(.PROP_DELAY(PD), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst),
        .A1(a_pins[0]), .A2(a_pins[1]), .A3(a_pins[2]), .A4(a_pins[3]),
        .B1(b_pins[0]), .B2(b_pins[1]), .B3(b_pins[2]), .B4(b_pins[3]),
        .op1(ops_s[0]), .op2(ops_s[1]), .op3(ops_s[2]), .op4(ops_s[3]),
        .powered(powered), .cfg_valid(cfg_valid), .cfg_ready(ready_s),
        .cfg_gate(cfg_gate), .cfg_fault_mask(cfg_fault_mask), .cfg_fault_val(cfg_fault_val),
        .busy(busy_s), .toggle_count(tc_s)
    );

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cyc = 0;
    bit          done = 1'b0;
    logic [7:0]  hist [4096];

    // Reference model state: 0 = off, 1 = flushing, 2 = running
    int          m_st;
    int          m_left;
    int          m_gate;
    logic [3:0]  m_mask;
    logic [3:0]  m_val;
    int unsigned m_cnt16;
    int unsigned m_cnt2;

    function automatic logic ref_gate(input int code, input logic a, input logic b);
        int s;
        s = int'(a) + int'(b);
        case (code)
            0:       return s == 2;
            1:       return s >= 1;
            2:       return s != 2;
            3:       return s == 0;
            4:       return s == 1;
            5:       return s != 1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] pat(input logic a, input logic b);
        return {{4{b}}, {4{a}}};
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    // Drive one cycle of pins/controls, advance the model across the next edge,
    // and queue what the outputs should show after that edge.
    task automatic step(input bit r, input bit p, input bit cv, input logic [7:0] pins);
        exp_t e;
        logic [7:0] src;
        rst       = r;
        powered   = p;
        cfg_valid = cv;
        a_pins    = pins[3:0];
        b_pins    = pins[7:4];
        hist[cyc] = pins;
        if (r) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
            m_gate  = 0;
            m_mask  = 4'h0;
            m_val   = 4'h0;
            m_st    = p ? 1 : 0;
            m_left  = PD;
        end else begin
            if (cyc >= 2 && hist[cyc-1] != hist[cyc-2]) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3)      m_cnt2++;
            end
            if (!p) begin
                m_st = 0;
            end else if (m_st == 0) begin
                m_st   = 1;
                m_left = PD;
            end else if (m_st == 1) begin
                if (m_left == 1) m_st = 2;
                else             m_left--;
            end else if (cv) begin
                m_gate = int'(cfg_gate);
                m_mask = cfg_fault_mask;
                m_val  = cfg_fault_val;
                m_st   = 1;
                m_left = PD;
            end
        end
        e.ops = 4'h0;
        if (m_st == 2) begin
            src = hist[cyc-PD];
            for (int i = 0; i < 4; i++) begin
                e.ops[i] = m_mask[i] ? m_val[i] : ref_gate(m_gate, src[i], src[i+4]);
            end
        end
        e.busy  = (m_st != 2);
        e.ready = (m_st == 2);
        e.cnt16 = m_cnt16;
        e.cnt2  = m_cnt2;
        @(posedge clk);
        sb_q.push_back(e);
        #1;
        cyc++;
    endtask

    task automatic hold(input int n, input logic [7:0] pins);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, pins);
    endtask

    task automatic configure(input logic [2:0] g, input logic [3:0] mk, input logic [3:0] v,
                             input logic [7:0] pins);
        cfg_gate       = g;
        cfg_fault_mask = mk;
        cfg_fault_val  = v;
        step(1'b0, 1'b1, 1'b1, pins);
        cfg_gate       = 3'd0;
        cfg_fault_mask = 4'h0;
        cfg_fault_val  = 4'h0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ops", 32'(ops_w), 32'(e.ops));
                chk("ops_w2_inst", 32'(ops_s), 32'(e.ops));
                chk("busy", 32'(busy_w), 32'(e.busy));
                chk("cfg_ready", 32'(ready_w), 32'(e.ready));
                chk("toggle_count", 32'(tc_w), e.cnt16);
                chk("toggle_count_sat", 32'(tc_s), e.cnt2);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : driver
        for (int i = 0; i < 4096; i++) hist[i] = 8'h00;
        rst = 1'b1; powered = 1'b1; cfg_valid = 1'b0;
        a_pins = 4'h0; b_pins = 4'h0;
        cfg_gate = 3'd0; cfg_fault_mask = 4'h0; cfg_fault_val = 4'h0;

        // Reset and power-up flush with AND
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        hold(PD + 3, 8'h00);
        hold(8, pat(1'b1, 1'b1));
        hold(8, pat(1'b1, 1'b0));

        // XOR truth table
        configure(3'd4, 4'h0, 4'h0, pat(1'b0, 1'b0));
        hold(PD + 3, pat(1'b0, 1'b0));
        hold(6, pat(1'b0, 1'b1));
        hold(6, pat(1'b1, 1'b0));
        hold(6, pat(1'b1, 1'b1));

        // NAND with gate 3 stuck at 0, then fault removed
        configure(3'd2, 4'b0100, 4'b0000, 8'h00);
        hold(PD + 4, 8'h00);
        configure(3'd2, 4'b0000, 4'b0000, 8'h00);
        hold(PD + 4, 8'h00);

        // Supply drop coinciding with an OR config request
        cfg_gate = 3'd1;
        step(1'b0, 1'b0, 1'b1, pat(1'b1, 1'b1));
        cfg_gate = 3'd0;
        step(1'b0, 1'b0, 1'b0, pat(1'b1, 1'b1));
        step(1'b0, 1'b0, 1'b0, pat(1'b0, 1'b1));
        hold(PD + 3, pat(1'b1, 1'b0));
        hold(6, pat(1'b1, 1'b1));

        // Invalid gate code
        configure(3'd7, 4'h0, 4'h0, 8'h00);
        hold(PD + 1, 8'h00);
        hold(4, pat(1'b0, 1'b1));
        hold(4, pat(1'b1, 1'b0));
        hold(4, pat(1'b1, 1'b1));

        // Randomised traffic: pins, config requests in any state, supply drops
        for (int i = 0; i < 700; i++) begin
            bit p;
            bit cv;
            p  = ($urandom_range(0, 39) != 0);
            cv = ($urandom_range(0, 9) == 0);
            cfg_gate       = 3'($urandom_range(0, 7));
            cfg_fault_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            cfg_fault_val  = 4'($urandom);
            step(1'b0, p, cv, 8'($urandom));
        end
        cfg_gate = 3'd0; cfg_fault_mask = 4'h0; cfg_fault_val = 4'h0;

        // Activity counter stepping and saturation from a fresh reset
        hold(3, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        hold(3, pat(1'b0, 1'b0));
        hold(3, pat(1'b0, 1'b1));
        hold(3, pat(1'b1, 1'b0));
        hold(3, pat(1'b1, 1'b1));
        hold(3, pat(1'b0, 1'b0));
        hold(3, pat(1'b0, 1'b0));
        step(1'b1, 1'b1, 1'b0, 8'h00);
        hold(2, 8'h00);

        done = 1'b1;
        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_quad2_gate_ic_emulator
`default_nettype wire
